gray_monitor: RTL
=================

Name: gray_monitor

Overview:
- Downstream consumer of the 3-bit Gray step counter.
- Samples the counter's Gray output and sticky overflow flag.
- Decodes the sample to binary, checks that every step is a legal Gray transition, counts completed laps (100->000 wraps) and illegal steps, and cross-checks the upstream overflow flag.
- Feeds status/debug registers and the board LED/segment stage.

Parameters:
- CNT_W, 8, width of LapCount and ErrCount; both saturate at 2^CNT_W-1.
- GRAY_W, 3, width of the Gray input. Fixed at 3; any other value is a synthesis error.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- Sample  input  1  qualifies GrayIn/OverflowIn this cycle.
- GrayIn  input  3  Gray-coded count from upstream.
- OverflowIn  input  1  upstream sticky overflow flag.
- Binary  output  3  registered binary decode of last accepted sample.
- StepErr  output  1  one-cycle pulse on an illegal step.
- Locked  output  1  high while state is S_TRACK.
- OvfErr  output  1  sticky; lap seen with OverflowIn=0.
- LapCount  output  CNT_W  number of 100->000 wraps observed.
- ErrCount  output  CNT_W  number of illegal steps observed.

Behaviour:
- Reset is checked first and wins over everything.
  - Outputs cleared: Binary=0, StepErr=0, Locked=0, OvfErr=0, LapCount=0, ErrCount=0.
  - State goes to S_INIT; prev register set to 0.
- Reset asserted mid-operation: same clearing; any in-progress fault state is discarded.
- Sample=0: no state, prev, Binary or count changes. StepErr=0 that cycle.
- Decode is combinational: b2=g2, b1=g2^g1, b0=g2^g1^g0.
- Registered outputs update on the edge after the accepted sample. Latency is 1 cycle.
- States:
  - S_INIT: waiting for the first sample.
  - S_TRACK: locked, checking each step.
  - S_FAULT: illegal step seen, waiting for resync.
- S_INIT, on Sample:
  - Accept any value: prev=decode, Binary=decode.
  - Go to S_TRACK. No checking, no counting.
- S_TRACK, on Sample, with d=decode(GrayIn) and p=prev:
  - d==p: hold, legal. No count change.
  - d==p+1 (mod 8), p!=7: legal step. prev=d.
  - p==7 and d==0: lap.
    - LapCount+1, saturating.
    - If OverflowIn==0 that same sample, set OvfErr; it stays 1 until Reset.
    - prev=0.
  - d==0 from any other p: upstream restart; legal, not a lap. prev=0.
  - Anything else is illegal:
    - StepErr=1 for one cycle; ErrCount+1, saturating.
    - Binary=d; prev unchanged.
    - Go to S_FAULT.
- S_FAULT, on Sample:
  - Binary always follows decode.
  - GrayIn==000: prev=0, go to S_TRACK.
  - Any other value: stay in S_FAULT, no further StepErr or ErrCount increments.
- Locked = (state==S_TRACK), registered.
- Saturation: at 2^CNT_W-1 the counters hold. Wrap-around of the counters is forbidden.
- OverflowIn is only sampled on a lap. Its level at other times is ignored.

Decomposition:
- gray_pkg holds:
  - GRAY_W=3 and the 2-bit state encodings S_INIT=0, S_TRACK=1, S_FAULT=2.
  - LAP_PREV=3'd7.
  - Function gray2bin.
- One combinational sub-module, gray_to_bin (3-bit Gray in, 3-bit binary out), instantiated once.
- Counters and FSM stay in gray_monitor.

Test Plan:
- Reset, then Sample every cycle with Gray 000,001,011,010,110,111,101,100,000 and OverflowIn=1 on the last sample.
  - Locked=1 from cycle 2; Binary steps 0..7 then 0.
  - LapCount=1, ErrCount=0, OvfErr=0.
- Same sequence with OverflowIn=0 at the wrap -> LapCount=1, OvfErr=1, and it stays 1 over a further 20 cycles.
- Sequence 000,001,110 (binary 0->1->4) -> StepErr pulses once, ErrCount=1, Locked=0.
  - Then 111,101 -> no further errors.
  - Then 000 -> Locked=1.
- Gray 011 held for 5 sampled cycles, plus Sample=0 cycles with GrayIn toggling -> no errors, Binary=2 throughout.
- 256 full laps with CNT_W=8 -> LapCount saturates at 255.
  - Reset asserted mid-lap -> all outputs 0 on the next edge; first sample after that is accepted without error.
- Sample at binary 5 then Gray 000 -> restart is legal: LapCount unchanged, ErrCount=0, Locked=1.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants, state encoding and Gray decode for the Gray step-counter monitor.
package gray_pkg;

    localparam int GRAY_W = 3;
    localparam logic [2:0] LAP_PREV = 3'd7;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

endpackage

// File: rtl/gray_monitor_if.sv
// Sample bus from the upstream Gray step counter into the monitor.
interface gray_monitor_if;
    import gray_pkg::*;

    logic              Sample;
    logic [GRAY_W-1:0] GrayIn;
    logic              OverflowIn;

    modport master (output Sample, output GrayIn, output OverflowIn);
    modport slave  (input  Sample, input  GrayIn, input  OverflowIn);
endinterface

// File: rtl/gray_to_bin.sv
// Combinational 3-bit Gray to binary decoder.
module gray_to_bin
    import gray_pkg::*;
(
    input  logic [2:0] gray_i,
    output logic [2:0] bin_o
);
    assign bin_o = gray2bin(gray_i);
endmodule

// File: rtl/gray_monitor.sv
// Tracks the upstream Gray counter: decodes samples, flags illegal steps,
// counts laps and illegal steps, and cross-checks the sticky overflow flag.
module gray_monitor #(
    parameter int CNT_W  = 8,
    parameter int GRAY_W = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    gray_monitor_if.slave    mon,
    output logic [2:0]       Binary,
    output logic             StepErr,
    output logic             Locked,
    output logic             OvfErr,
    output logic [CNT_W-1:0] LapCount,
    output logic [CNT_W-1:0] ErrCount
);
    import gray_pkg::*;

    if (GRAY_W != 3) begin : g_bad_width
        $error("gray_monitor: GRAY_W must be 3");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [2:0]       binary_q, binary_d;
    logic             step_err_q, step_err_d;
    logic             locked_q, locked_d;
    logic             ovf_err_q, ovf_err_d;
    logic [CNT_W-1:0] lap_cnt_q, lap_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [2:0]       dec;

    gray_to_bin u_dec (
        .gray_i (mon.GrayIn),
        .bin_o  (dec)
    );

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        binary_d   = binary_q;
        step_err_d = 1'b0;
        ovf_err_d  = ovf_err_q;
        lap_cnt_d  = lap_cnt_q;
        err_cnt_d  = err_cnt_q;

        if (mon.Sample) begin
            binary_d = dec;
            case (state_q)
                S_INIT: begin
                    prev_d  = dec;
                    state_d = S_TRACK;
                end
                S_TRACK: begin
                    // A repeated value is a legal hold and changes nothing.
                    if (dec != prev_q) begin
                        if (prev_q != LAP_PREV && dec == prev_q + 3'd1) begin
                            prev_d = dec;
                        end else if (prev_q == LAP_PREV && dec == 3'd0) begin
                            if (lap_cnt_q != CNT_MAX) lap_cnt_d = lap_cnt_q + 1'b1;
                            if (!mon.OverflowIn) ovf_err_d = 1'b1;
                            prev_d = 3'd0;
                        end else if (dec == 3'd0) begin
                            prev_d = 3'd0;
                        end else begin
                            step_err_d = 1'b1;
                            if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
                            state_d = S_FAULT;
                        end
                    end
                end
                S_FAULT: begin
                    // Only a zero sample resynchronises; prev is stale until then.
                    if (dec == 3'd0) begin
                        prev_d  = 3'd0;
                        state_d = S_TRACK;
                    end
                end
                default: state_d = S_INIT;
            endcase
        end

        locked_d = (state_d == S_TRACK);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_INIT;
            prev_q     <= 3'd0;
            binary_q   <= 3'd0;
            step_err_q <= 1'b0;
            locked_q   <= 1'b0;
            ovf_err_q  <= 1'b0;
            lap_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            binary_q   <= binary_d;
            step_err_q <= step_err_d;
            locked_q   <= locked_d;
            ovf_err_q  <= ovf_err_d;
            lap_cnt_q  <= lap_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign Binary   = binary_q;
    assign StepErr  = step_err_q;
    assign Locked   = locked_q;
    assign OvfErr   = ovf_err_q;
    assign LapCount = lap_cnt_q;
    assign ErrCount = err_cnt_q;

endmodule
